// File: rtl/uart_tx_stimulus_gen_pkg.sv
// Shared definitions for the UART loopback stimulus source and its checker model.
package uart_tb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SEND    = 3'd1,
    ST_WAIT    = 3'd2,
    ST_GAP     = 3'd3,
    ST_DONE    = 3'd4,
    ST_TIMEOUT = 3'd5
  } state_t;

  // Feedback taps of x^8+x^6+x^5+x^4+1 for a left-shifting Fibonacci LFSR: bits 7,5,4,3.
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  function automatic logic [7:0] lfsr8_next(input logic [7:0] d);
    return {d[6:0], ^(d & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/uart_tx_stimulus_gen.sv
// Byte stimulus source for the UART loopback setup: issues LFSR bytes to the TX
// core, paced by TX/RX completion handshakes, with an inter-byte gap and timeout.
module uart_tx_stimulus_gen
  import uart_tb_pkg::*;
#(
  parameter int unsigned NUM_BYTES      = 16,
  parameter logic [7:0]  LFSR_SEED      = 8'hA5,
  parameter int unsigned GAP_CYCLES     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 20000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_start,
  input  logic        i_tx_done,
  input  logic        i_rx_done,
  output logic        o_tx_start,
  output logic [7:0]  o_tx_data,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_timeout,
  output logic [15:0] o_sent_count
);

  localparam int unsigned CW = $clog2(NUM_BYTES + 1);
  localparam int unsigned GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [7:0]    SEED_EFF = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;
  localparam logic [CW-1:0] CNT_LAST = CW'(NUM_BYTES - 1);
  localparam logic [GW-1:0] GAP_LAST = (GAP_CYCLES > 0) ? GW'(GAP_CYCLES - 1) : '0;
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);

  state_t          r_state;
  logic [7:0]      r_lfsr;
  logic [7:0]      r_tx_data;
  logic [CW-1:0]   r_cnt;
  logic [GW-1:0]   r_gap_cnt;
  logic [TW-1:0]   r_to_cnt;
  logic            r_tx_flag;
  logic            r_rx_flag;

  state_t          w_state_nxt;
  logic [7:0]      w_lfsr_nxt;
  logic [CW-1:0]   w_cnt_nxt;
  logic [GW-1:0]   w_gap_nxt;
  logic [TW-1:0]   w_to_nxt;
  logic            w_tx_flag_nxt;
  logic            w_rx_flag_nxt;
  logic            w_tx_seen;
  logic            w_rx_seen;
  logic            w_complete;

  // Next-state, counter and LFSR decisions for the run sequencer.
  always_comb begin
    w_state_nxt   = r_state;
    w_lfsr_nxt    = r_lfsr;
    w_cnt_nxt     = r_cnt;
    w_gap_nxt     = r_gap_cnt;
    w_to_nxt      = r_to_cnt;
    w_tx_flag_nxt = r_tx_flag;
    w_rx_flag_nxt = r_rx_flag;
    // A handshake pulse counts in the very cycle it arrives.
    w_tx_seen     = r_tx_flag | i_tx_done;
    w_rx_seen     = r_rx_flag | i_rx_done;
    w_complete    = (r_state == ST_WAIT) && w_tx_seen && w_rx_seen;

    case (r_state)
      ST_IDLE, ST_DONE, ST_TIMEOUT: begin
        if (i_start) begin
          w_state_nxt = ST_SEND;
          w_cnt_nxt   = '0;
          w_lfsr_nxt  = SEED_EFF;
        end
      end
      ST_SEND: begin
        w_state_nxt   = ST_WAIT;
        w_tx_flag_nxt = 1'b0;
        w_rx_flag_nxt = 1'b0;
        w_to_nxt      = '0;
      end
      ST_WAIT: begin
        w_tx_flag_nxt = w_tx_seen;
        w_rx_flag_nxt = w_rx_seen;
        // Completion is tested before timeout so it wins a same-cycle tie.
        if (w_complete) begin
          w_cnt_nxt  = r_cnt + 1'b1;
          w_lfsr_nxt = lfsr8_next(r_lfsr);
          if (r_cnt == CNT_LAST) begin
            w_state_nxt = ST_DONE;
          end else if (GAP_CYCLES == 0) begin
            w_state_nxt = ST_SEND;
          end else begin
            w_state_nxt = ST_GAP;
            w_gap_nxt   = '0;
          end
        end else if (r_to_cnt == TO_LAST) begin
          w_state_nxt = ST_TIMEOUT;
        end else begin
          w_to_nxt = r_to_cnt + 1'b1;
        end
      end
      ST_GAP: begin
        if (r_gap_cnt == GAP_LAST) begin
          w_state_nxt = ST_SEND;
        end else begin
          w_gap_nxt = r_gap_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any run in progress.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= ST_IDLE;
      r_lfsr    <= SEED_EFF;
      r_tx_data <= '0;
      r_cnt     <= '0;
      r_gap_cnt <= '0;
      r_to_cnt  <= '0;
      r_tx_flag <= 1'b0;
      r_rx_flag <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_lfsr    <= w_lfsr_nxt;
      r_cnt     <= w_cnt_nxt;
      r_gap_cnt <= w_gap_nxt;
      r_to_cnt  <= w_to_nxt;
      r_tx_flag <= w_tx_flag_nxt;
      r_rx_flag <= w_rx_flag_nxt;
      // Capture the byte on entry to SEND so it is valid during the start pulse
      // and stays put until the next one.
      if (w_state_nxt == ST_SEND) begin
        r_tx_data <= w_lfsr_nxt;
      end
    end
  end

  assign o_tx_start   = (r_state == ST_SEND);
  assign o_tx_data    = r_tx_data;
  assign o_busy       = (r_state == ST_SEND) || (r_state == ST_WAIT) || (r_state == ST_GAP);
  assign o_done       = (r_state == ST_DONE);
  assign o_timeout    = (r_state == ST_TIMEOUT);
  assign o_sent_count = 16'(r_cnt);

endmodule

// File: tb/tb_uart_tx_stimulus_gen.sv
// Directed/randomized bench for uart_tx_stimulus_gen: two instances (gapped and
// gapless configurations) checked against a byte-sequence and timing model.
module tb_uart_tx_stimulus_gen;

  localparam int A_NUM = 3;
  localparam int A_GAP = 4;
  localparam int A_TO  = 50;
  localparam int B_NUM = 4;
  localparam int B_GAP = 0;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_start, a_txd, a_rxd;
  logic        a_txs, a_busy, a_done, a_to;
  logic [7:0]  a_data;
  logic [15:0] a_sent;
  logic        b_start, b_txd, b_rxd;
  logic        b_txs, b_busy, b_done, b_to;
  logic [7:0]  b_data;
  logic [15:0] b_sent;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int start_cyc;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  uart_tx_stimulus_gen #(.NUM_BYTES(A_NUM), .LFSR_SEED(8'hA5), .GAP_CYCLES(A_GAP),
                         .TIMEOUT_CYCLES(A_TO)) u_a (
    .i_clk(clk), .i_reset(rst), .i_start(a_start), .i_tx_done(a_txd), .i_rx_done(a_rxd),
    .o_tx_start(a_txs), .o_tx_data(a_data), .o_busy(a_busy), .o_done(a_done),
    .o_timeout(a_to), .o_sent_count(a_sent));

  uart_tx_stimulus_gen #(.NUM_BYTES(B_NUM), .LFSR_SEED(8'h00), .GAP_CYCLES(B_GAP),
                         .TIMEOUT_CYCLES(50)) u_b (
    .i_clk(clk), .i_reset(rst), .i_start(b_start), .i_tx_done(b_txd), .i_rx_done(b_rxd),
    .o_tx_start(b_txs), .o_tx_data(b_data), .o_busy(b_busy), .o_done(b_done),
    .o_timeout(b_to), .o_sent_count(b_sent));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // n-th byte of a run: apply the shift-left / tap-parity rule n times to the seed.
  function automatic logic [7:0] ref_byte(input logic [7:0] seed, input int n);
    logic [7:0] s;
    s = (seed == 8'h00) ? 8'h01 : seed;
    repeat (n) s = {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    return s;
  endfunction

  function automatic logic  txs (input bit w); return w ? b_txs  : a_txs;  endfunction
  function automatic logic [7:0] dat(input bit w); return w ? b_data : a_data; endfunction
  function automatic logic  bsy (input bit w); return w ? b_busy : a_busy; endfunction
  function automatic logic  dn  (input bit w); return w ? b_done : a_done; endfunction
  function automatic logic  tmo (input bit w); return w ? b_to   : a_to;   endfunction
  function automatic logic [15:0] snt(input bit w); return w ? b_sent : a_sent; endfunction

  task automatic drive(input bit w, input logic st, input logic td, input logic rd);
    if (w) begin b_start = st; b_txd = td; b_rxd = rd; end
    else   begin a_start = st; a_txd = td; a_rxd = rd; end
  endtask

  // Called on the negedge where the triggering stimulus was applied.
  task automatic wait_start(input bit w, input int exp_dist, input logic [7:0] exp_data,
                            input int exp_sent, input string tag);
    int n;
    bit seen;
    n = 0;
    seen = 0;
    while (n < 200 && !seen) begin
      @(negedge clk);
      drive(w, 1'b0, 1'b0, 1'b0);
      n++;
      seen = txs(w);
    end
    chk({tag, " start seen"}, 32'(seen), 32'd1);
    if (seen) begin
      start_cyc = cyc;
      chk({tag, " start dist"}, n, exp_dist);
      chk({tag, " data"}, 32'(dat(w)), 32'(exp_data));
      chk({tag, " sent"}, 32'(snt(w)), exp_sent);
      chk({tag, " busy/done/to"}, {bsy(w), dn(w), tmo(w)}, 32'b100);
    end
  endtask

  // Starts on the tx_start negedge; delay 0 means the pulse is never given.
  task automatic respond(input bit w, input int dtx, input int drx, input int st_at,
                         input string tag);
    int last;
    int spurious;
    last = (dtx > drx) ? dtx : drx;
    spurious = 0;
    for (int t = 1; t <= last; t++) begin
      @(negedge clk);
      if (txs(w)) spurious++;
      drive(w, (t == st_at), (t == dtx), (t == drx));
    end
    chk({tag, " no extra start"}, spurious, 0);
  endtask

  task automatic finish_run(input bit w, input int nb, input string tag);
    int spurious;
    @(negedge clk);
    drive(w, 1'b0, 1'b0, 1'b0);
    chk({tag, " end done/busy/to"}, {dn(w), bsy(w), tmo(w)}, 32'b100);
    chk({tag, " end sent"}, 32'(snt(w)), nb);
    spurious = 0;
    repeat (10) begin
      @(negedge clk);
      if (txs(w)) spurious++;
    end
    chk({tag, " idle after done"}, spurious, 0);
  endtask

  // mode 0: both pulses 10 clocks after start; 1: random; 2: rx-before-tx then same-cycle.
  task automatic full_run(input bit w, input int nb, input int gap, input logic [7:0] seed,
                          input int mode, input bit busy_start, input string tag);
    int dtx, drx, prev;
    @(negedge clk);
    drive(w, 1'b1, 1'b0, 1'b0);
    prev = 0;
    for (int i = 0; i < nb; i++) begin
      wait_start(w, (i == 0) ? 1 : gap + 1, ref_byte(seed, i), i, tag);
      if (mode == 0 && i > 0) chk({tag, " start interval"}, start_cyc - prev, 10 + gap + 1);
      prev = start_cyc;
      dtx = int'($urandom_range(20, 1));
      drx = int'($urandom_range(20, 1));
      if (mode == 0) begin dtx = 10; drx = 10; end
      if (mode == 2 && i == 0) begin dtx = 5; drx = 3; end
      if (mode == 2 && i == 1) begin dtx = 6; drx = 6; end
      respond(w, dtx, drx, (busy_start && i == 1) ? 1 : 0, tag);
    end
    finish_run(w, nb, tag);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, spurious;
    bit seen;
    rst = 1'b1;
    drive(0, 1'b0, 1'b0, 1'b0);
    drive(1, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    chk("reset tx_start", 32'(a_txs), 32'd0);
    chk("reset tx_data", 32'(a_data), 32'd0);
    chk("reset busy/done/to", {a_busy, a_done, a_to}, 32'd0);
    chk("reset sent", 32'(a_sent), 32'd0);
    chk("reset b flags", {b_txs, b_busy, b_done, b_to}, 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    full_run(0, A_NUM, A_GAP, 8'hA5, 0, 0, "basic");
    full_run(0, A_NUM, A_GAP, 8'hA5, 2, 0, "order");

    // Timeout on byte 2: tx_done given, rx_done withheld.
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 1'b0);
    wait_start(0, 1, ref_byte(8'hA5, 0), 0, "tmo b0");
    respond(0, int'($urandom_range(20, 1)), int'($urandom_range(20, 1)), 0, "tmo b0");
    wait_start(0, A_GAP + 1, ref_byte(8'hA5, 1), 1, "tmo b1");
    t = 0;
    seen = 0;
    spurious = 0;
    while (t < 80 && !seen) begin
      @(negedge clk);
      t++;
      if (a_txs) spurious++;
      drive(0, 1'b0, (t == 4), 1'b0);
      seen = a_to;
    end
    chk("timeout seen", 32'(seen), 32'd1);
    chk("timeout latency window", 32'(t >= A_TO && t <= A_TO + 2), 32'd1);
    chk("timeout no extra start", spurious, 0);
    chk("timeout sent", 32'(a_sent), 32'd1);
    chk("timeout busy/done", {a_busy, a_done}, 32'd0);
    spurious = 0;
    repeat (20) begin
      @(negedge clk);
      if (a_txs) spurious++;
    end
    chk("timeout idle", spurious, 0);
    chk("timeout held", 32'(a_to), 32'd1);

    // Restart after timeout; then reset while waiting on byte 1.
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 1'b0);
    wait_start(0, 1, 8'hA5, 0, "restart");
    respond(0, 2, 0, 0, "restart");
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst tx_start/busy/done/to", {a_txs, a_busy, a_done, a_to}, 32'd0);
    chk("midrst data", 32'(a_data), 32'd0);
    chk("midrst sent", 32'(a_sent), 32'd0);
    spurious = 0;
    repeat (30) begin
      @(negedge clk);
      if (a_txs || a_busy) spurious++;
    end
    chk("midrst quiet", spurious, 0);

    for (int r = 0; r < 3; r++) full_run(0, A_NUM, A_GAP, 8'hA5, 1, 0, "rand a");

    // Gapless instance with zero seed; a stray i_start lands mid-run.
    full_run(1, B_NUM, B_GAP, 8'h00, 1, 1, "gap0");
    full_run(1, B_NUM, B_GAP, 8'h00, 2, 0, "gap0 order");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_stimulus_gen.md
Name: uart_tx_stimulus_gen

Overview:
Synthesizable byte-stimulus source that sits directly upstream of the UART transmitter in the loopback test setup. It produces the tx_start/tx_data pair consumed by the TX core and the result checker. Bytes come from an 8-bit LFSR. Each byte is paced by the TX-done and RX-done handshakes, with an inter-byte gap and a per-byte timeout.

Parameters:
NUM_BYTES, 16, number of bytes per run (1..65535)
LFSR_SEED, 8'hA5, first byte of every run; a value of 0 is replaced by 8'h01
GAP_CYCLES, 32, idle clocks between completion of one byte and the tx_start of the next (0 allowed)
TIMEOUT_CYCLES, 20000, maximum clocks from a tx_start pulse to completion of both handshakes

Ports:
i_clk  in  1  system clock
i_reset  in  1  synchronous, active-high reset
i_start  in  1  one-cycle request to begin a run; sampled only in IDLE, DONE or TIMEOUT
i_tx_done  in  1  one-cycle pulse: TX core finished the stop bit
i_rx_done  in  1  one-cycle pulse: RX core delivered a byte
o_tx_start  out  1  one-cycle start pulse to the TX core
o_tx_data  out  8  byte for TX; valid on the o_tx_start cycle and held until the next o_tx_start
o_busy  out  1  high while a run is in progress
o_done  out  1  level; run completed; cleared by i_start or reset
o_timeout  out  1  level; run aborted by timeout; cleared by i_start or reset
o_sent_count  out  16  bytes fully completed in the current run

Behaviour:
- Reset (i_clk edge with i_reset=1): state IDLE. o_tx_start=0, o_tx_data=0, o_busy=0, o_done=0, o_timeout=0, o_sent_count=0, LFSR=seed. Reset mid-run aborts immediately; no further o_tx_start is issued.
- LFSR: Fibonacci, polynomial x^8+x^6+x^5+x^4+1, shift left, fb = d[7]^d[5]^d[4]^d[3], next = {d[6:0], fb}. Advances once per completed byte.
- Byte sequence from seed A5: A5, 4A, 95, ...
- FSM states: IDLE, SEND, WAIT, GAP, DONE, TIMEOUT.
- IDLE/DONE/TIMEOUT + i_start: clear o_done, o_timeout, o_sent_count; load LFSR=seed; go to SEND; o_busy=1 from the next cycle.
- SEND (1 cycle): o_tx_start=1, o_tx_data=LFSR; clear both done-flags; clear timeout counter; go to WAIT. o_tx_start rises exactly one cycle after i_start.
- WAIT: set tx_flag on i_tx_done and rx_flag on i_rx_done. Pulses may arrive in either order or in the same cycle. Pulses in the SEND cycle itself are ignored.
- WAIT, when both flags are set (a pulse counts in the same cycle it arrives): o_sent_count+1, advance LFSR.
  - If count==NUM_BYTES: go to DONE, o_done=1, o_busy=0.
  - Else if GAP_CYCLES==0: go to SEND.
  - Else: go to GAP.
- GAP: counts GAP_CYCLES clocks, then SEND. The next o_tx_start follows the completing pulse by GAP_CYCLES+1 clocks.
- Timeout: counter runs in WAIT. If it reaches TIMEOUT_CYCLES without both flags set: go to TIMEOUT, o_timeout=1, o_busy=0; o_sent_count holds.
  - Completion and timeout in the same cycle: completion wins.
- Extra done pulses outside WAIT are ignored. i_start while busy is ignored.
- Counters are sized by $clog2 of their parameter+1. o_sent_count is zero-extended to 16 bits.

Decomposition:
- Shared package uart_tb_pkg:
  - state enum typedef (6 states, 3-bit)
  - LFSR polynomial tap constant
  - function lfsr8_next(byte) -> byte, reused by the checker model
- Sub-module: none required. The LFSR step is the package function.

Test Plan:
- Basic run, NUM_BYTES=3, GAP=4, i_tx_done and i_rx_done pulsed 10 clocks after each o_tx_start -> bytes A5, 4A, 95; start pulses 15 clocks apart; o_done=1 with o_sent_count=3.
- Handshake order: rx_done 2 clocks before tx_done, then both in the same cycle -> each byte completes on the later or shared pulse; no byte is skipped or duplicated.
- Timeout, TIMEOUT_CYCLES=50, tx_done given but rx_done withheld on byte 2 -> o_timeout=1 about 50 clocks after the 2nd start; o_sent_count=1; no further o_tx_start.
- Restart after timeout with i_start -> o_timeout clears; first byte is again A5; o_sent_count resets to 0.
- Reset asserted in WAIT mid-run -> next cycle all outputs are at reset values; no o_tx_start afterwards until i_start.
- GAP_CYCLES=0 and LFSR_SEED=0 -> first byte is 01, second 02; back-to-back start pulses 1 clock after completion; i_start while busy has no effect.
